pulse_reporter: RTL and testbench

PULSE_REPORTER -- requirements
Module: pulse_reporter

---
 rtl/pulse_reporter_pkg.sv | 36 +++
 rtl/uart_tx_byte.sv | 65 ++++++
 rtl/pulse_reporter.sv | 164 ++++++++++++++++
 tb/tb_pulse_reporter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_reporter_pkg.sv
// Shared types and constants for the pulse reporter: FSM states, ASCII framing
// bytes and the helper that picks each byte of the "DDD\r\n" report.
package pulse_reporter_pkg;

    localparam int CNT_W_DEF = 9;
    localparam int FRAME_LEN = 5;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_WAIT_TICK,
        ST_SEND
    } state_t;

    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [3:0] hun,
        input logic [3:0] ten,
        input logic [3:0] unit
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_0 + {4'd0, hun};
            3'd1:    b = ASCII_0 + {4'd0, ten};
            3'd2:    b = ASCII_0 + {4'd0, unit};
            3'd3:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer paced by the shared tick; a start presented with the tick
// that ends a stop bit chains the next byte with no idle gap.
module uart_tx_byte (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    logic       active_q, active_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;

    // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done     = 1'b0;
        if (tick) begin
            if (active_q && bit_q != 4'd9) begin
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd8) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end else begin
                done = active_q;
                if (start) begin
                    active_d = 1'b1;
                    bit_d    = 4'd0;
                    shift_d  = data;
                    tx_d     = 1'b0;
                end else begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/pulse_reporter.sv
// Measures the length of each input pulse in ticks and reports it over UART as
// three ASCII decimal digits followed by CR LF.
module pulse_reporter
    import pulse_reporter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic tick,
    input  logic pulse_in,
    input  logic ovr_clr,
    output logic tx,
    output logic busy,
    output logic overrun
);

    localparam int              CONV_W  = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]        fill_q, fill_d;
    logic              armed_q, armed_d, meas_q, meas_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cap_q, cap_d;
    logic [11:0]       bcd_q, bcd_d, bcd_adj;
    logic [CONV_W-1:0] conv_q, conv_d;
    logic [2:0]        byte_q, byte_d, byte_sel;
    logic              ovr_q, ovr_d;
    state_t            state_q, state_d;
    logic              rise, fall, ser_start, ser_tx, ser_done;
    logic [7:0]        ser_data;

    // armed_q only rises once a genuine low has been sampled after reset, so a
    // pulse already high at reset release is never measured.
    assign rise = armed_q & sync2_q & ~prev_q;
    assign fall = meas_q & prev_q & ~sync2_q;

    always_comb begin
        sync1_d = pulse_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
        meas_d  = meas_q;
        cnt_d   = cnt_q;
        if (rise) begin
            meas_d = 1'b1;
            cnt_d  = '0;
        end else begin
            if (fall)
                meas_d = 1'b0;
            if (meas_q && sync2_q && tick && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (fall && state_q != ST_IDLE)
            ovr_d = 1'b1;
        else if (ovr_clr)
            ovr_d = 1'b0;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    // While sending, the byte to load next is the one after the current index.
    assign byte_sel = (state_q == ST_SEND) ? byte_q + 3'd1 : byte_q;
    assign ser_data = frame_byte(byte_sel, bcd_q[11:8], bcd_q[7:4], bcd_q[3:0]);

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        bcd_d     = bcd_q;
        conv_d    = conv_q;
        byte_d    = byte_q;
        ser_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    cap_d   = cnt_q;
                    bcd_d   = '0;
                    conv_d  = '0;
                    byte_d  = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_d  = {bcd_adj[10:0], cap_q[CNT_W-1]};
                cap_d  = {cap_q[CNT_W-2:0], 1'b0};
                conv_d = conv_q + 1'b1;
                if (conv_q == CONV_W'(CNT_W - 1))
                    state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (tick) begin
                    ser_start = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    if (byte_q == 3'(FRAME_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_d    = byte_q + 3'd1;
                        ser_start = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            meas_q  <= 1'b0;
            cnt_q   <= '0;
            cap_q   <= '0;
            bcd_q   <= '0;
            conv_q  <= '0;
            byte_q  <= '0;
            ovr_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            meas_q  <= meas_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            bcd_q   <= bcd_d;
            conv_q  <= conv_d;
            byte_q  <= byte_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    uart_tx_byte u_tx (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .tick   (tick),
        .start  (ser_start),
        .data   (ser_data),
        .tx     (ser_tx),
        .done   (ser_done)
    );

    assign tx      = (state_q == ST_SEND) ? ser_tx : 1'b1;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_pulse_reporter.sv
// Bench for pulse_reporter: random-length pulses on a fixed tick grid, UART
// decoding of tx, and comparison against frames computed from the pulse lengths.
module tb_pulse_reporter;

    logic sysclk   = 1'b0;
    logic rst_n    = 1'b0;
    logic tick     = 1'b0;
    logic pulse_in = 1'b0;
    logic ovr_clr  = 1'b0;
    logic tx, busy, overrun;

    pulse_reporter #(.CNT_W(9)) dut (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .tick     (tick),
        .pulse_in (pulse_in),
        .ovr_clr  (ovr_clr),
        .tx       (tx),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int phase = 0;

    // UART receiver: one mid-bit sample per tick interval
    logic [7:0] rx_q[$];
    int         rx_pos[$];
    int         samp = 0;
    int         ferr = 0;
    int         rx_cnt = -1;
    int         rx_start = 0;
    logic [7:0] rx_sh = 8'h00;

    initial begin
        forever begin
            @(negedge sysclk);
            cyc++;
            phase = cyc % 8;
            tick  = (phase == 0);
            if (phase == 4) begin
                samp++;
                if (!rst_n) begin
                    rx_cnt = -1;
                end else if (rx_cnt < 0) begin
                    if (tx == 1'b0) begin
                        rx_cnt   = 0;
                        rx_start = samp;
                    end
                end else if (rx_cnt < 8) begin
                    rx_sh = {tx, rx_sh[7:1]};
                    rx_cnt++;
                end else begin
                    if (tx !== 1'b1) ferr++;
                    rx_q.push_back(rx_sh);
                    rx_pos.push_back(rx_start);
                    rx_cnt = -1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_phase(input int p);
        do @(posedge sysclk); while (phase != p);
    endtask

    // Pulse rises and falls mid-interval so exactly n ticks fall inside it.
    task automatic do_pulse(input int n);
        wait_phase(2);
        #2 pulse_in = 1'b1;
        if (n == 0) begin
            wait_phase(5);
        end else begin
            repeat (n) wait_phase(2);
        end
        #2 pulse_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(posedge sysclk);
            #1;
            k++;
        end
        chk({tag, "_done"}, (k < 3000) ? 1 : 0, 1);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_pos.delete();
    endtask

    task automatic check_frame(input string tag, input int n);
        int v;
        logic [7:0] e [5];
        v = (n > 511) ? 511 : n;
        e[0] = 8'(48 + v / 100);
        e[1] = 8'(48 + (v / 10) % 10);
        e[2] = 8'(48 + v % 10);
        e[3] = 8'h0D;
        e[4] = 8'h0A;
        chk({tag, "_nbytes"}, rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size())
                chk($sformatf("%s_byte%0d", tag, i), int'(rx_q[i]), int'(e[i]));
        for (int i = 0; i < 4; i++)
            if (i + 1 < rx_pos.size())
                chk($sformatf("%s_gap%0d", tag, i), rx_pos[i+1] - rx_pos[i], 10);
    endtask

    task automatic run_one(input string tag, input int n);
        clear_rx();
        do_pulse(n);
        repeat (8) @(posedge sysclk);
        #1 chk({tag, "_busy"}, int'(busy), 1);
        wait_idle(tag);
        check_frame(tag, n);
        chk({tag, "_ovr"}, int'(overrun), 0);
        $display("pulse %s ticks=%0d bytes=%0d overrun=%0b", tag, n, rx_q.size(), overrun);
    endtask

    initial begin
        int n;
        int k;

        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(overrun), 0);

        // pulse already high at reset release must not be reported
        pulse_in = 1'b1;
        repeat (2) @(posedge sysclk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge sysclk);
        #2 pulse_in = 1'b0;
        repeat (100) @(posedge sysclk);
        #1;
        chk("stale_busy", int'(busy), 0);
        chk("stale_bytes", rx_q.size(), 0);

        run_one("p131", 131);
        run_one("p392", 392);
        run_one("glitch", 0);
        run_one("p600", 600);
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 520);
            run_one($sformatf("rnd%0d", r), n);
        end

        // A frame spans about 50 tick intervals, so the dropped pulse is kept shorter.
        clear_rx();
        do_pulse(131);
        repeat (8) @(posedge sysclk);
        do_pulse(20);
        repeat (8) @(posedge sysclk);
        #1 chk("ovr_set", int'(overrun), 1);
        wait_idle("ovr");
        repeat (200) @(posedge sysclk);
        #1;
        check_frame("ovr", 131);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_idle", int'(busy), 0);
        $display("overrun frame bytes=%0d overrun=%0b", rx_q.size(), overrun);
        @(posedge sysclk);
        #2 ovr_clr = 1'b1;
        @(posedge sysclk);
        #2 ovr_clr = 1'b0;
        #1 chk("ovr_clr", int'(overrun), 0);
        run_one("p87", 87);

        // reset in the middle of the third byte ('0' -> low data bits)
        clear_rx();
        do_pulse(250);
        k = 0;
        while (rx_q.size() < 2 && k < 3000) begin
            @(posedge sysclk);
            k++;
        end
        chk("mid_reach", (k < 3000) ? 1 : 0, 1);
        repeat (3) wait_phase(2);
        #1 chk("mid_tx_low", int'(tx), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_busy", int'(busy), 0);
        $display("reset mid-frame tx=%0b busy=%0b", tx, busy);
        repeat (20) @(posedge sysclk);
        #2 rst_n = 1'b1;
        clear_rx();
        repeat (800) @(posedge sysclk);
        #1;
        chk("post_rst_bytes", rx_q.size(), 0);
        chk("post_rst_busy", int'(busy), 0);
        run_one("post_rst", 7);

        chk("framing", ferr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
